stack_ctrl: RTL

- Sequencer for PUSH/POP/CALL/RET instructions.
- Reads the stack pointer (R3 of the 4x8 register file) and runs a single-beat handshake with data memory.
- Writes the updated SP, and the POP destination register, back through the register file's single write port.
- Sits beside the pipeline: the decode stage issues a request and stalls until it completes.

---
 rtl/stack_ctrl_if.sv | 32 +++
 rtl/stack_ctrl.sv | 84 ++++++++
 2 files changed

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: request, register-file and data-memory signals of the stack sequencer.
interface stack_ctrl_if;
   logic       req_valid;
   logic [1:0] req_op;
   logic [7:0] req_data;
   logic [1:0] req_dst;
   logic       req_ready;
   logic [7:0] sp_in;
   logic       rf_wr_en;
   logic [1:0] rf_wr_addr;
   logic [7:0] rf_wr_data;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_ack;
   logic [7:0] mem_rdata;
   logic       done_valid;
   logic [7:0] done_data;
   logic       done_is_ret;
   logic       err;
   modport slave (
      input  req_valid, req_op, req_data, req_dst, sp_in, mem_ack, mem_rdata,
      output req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, mem_req, mem_we, mem_addr,
             mem_wdata, done_valid, done_data, done_is_ret, err
   );
   modport master (
      output req_valid, req_op, req_data, req_dst, sp_in, mem_ack, mem_rdata,
      input  req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, mem_req, mem_we, mem_addr,
             mem_wdata, done_valid, done_data, done_is_ret, err
   );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: PUSH/POP/CALL/RET sequencer driving data memory and the register-file write port.
module stack_ctrl #(
   parameter logic [1:0] SP_ADDR  = 2'b11,
   parameter logic [7:0] SP_EMPTY = 8'hFF,
   parameter logic [7:0] SP_LIMIT = 8'h00
) (
   input logic        clk,
   input logic        rst_n,
   stack_ctrl_if.slave bus
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] MEM   = 3'd1;
   localparam logic [2:0] SPWB  = 3'd2;
   localparam logic [2:0] DSTWB = 3'd3;
   localparam logic [2:0] ERR   = 3'd4;
   localparam logic [1:0] OP_POP = 2'b01;
   localparam logic [1:0] OP_RET = 2'b11;
   logic [2:0] state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [7:0] data_q, data_d;
   logic [1:0] dst_q, dst_d;
   logic [7:0] sp_q, sp_d;
   logic [7:0] pop_q, pop_d;
   logic       is_read, in_mem, in_spwb, in_dstwb;
   // op bit 0 set means the stack is read (POP/RET), clear means written (PUSH/CALL)
   assign is_read  = op_q[0];
   assign in_mem   = state_q == MEM;
   assign in_spwb  = state_q == SPWB;
   assign in_dstwb = state_q == DSTWB;
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      dst_d   = dst_q;
      sp_d    = sp_q;
      pop_d   = pop_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            op_d    = bus.req_op;
            data_d  = bus.req_data;
            dst_d   = bus.req_dst;
            sp_d    = bus.sp_in;
            state_d = ((!bus.req_op[0] && bus.sp_in == SP_LIMIT) ||
                       (bus.req_op[0] && bus.sp_in == SP_EMPTY)) ? ERR : MEM;
         end
         MEM: if (bus.mem_ack) begin
            pop_d   = bus.mem_rdata;
            state_d = SPWB;
         end
         SPWB:    state_d = (op_q == OP_POP) ? DSTWB : IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         data_q  <= '0;
         dst_q   <= '0;
         sp_q    <= '0;
         pop_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         dst_q   <= dst_d;
         sp_q    <= sp_d;
         pop_q   <= pop_d;
      end
   end
   assign bus.req_ready   = state_q == IDLE;
   assign bus.mem_req     = in_mem;
   assign bus.mem_we      = in_mem && !is_read;
   assign bus.mem_addr    = in_mem ? (is_read ? sp_q + 8'd1 : sp_q) : 8'h00;
   assign bus.mem_wdata   = (in_mem && !is_read) ? data_q : 8'h00;
   assign bus.rf_wr_en    = in_spwb || in_dstwb;
   assign bus.rf_wr_addr  = in_spwb ? SP_ADDR : (in_dstwb ? dst_q : 2'b00);
   assign bus.rf_wr_data  = in_spwb ? (is_read ? sp_q + 8'd1 : sp_q - 8'd1) :
                            (in_dstwb ? pop_q : 8'h00);
   assign bus.done_valid  = (in_spwb && op_q != OP_POP) || in_dstwb;
   assign bus.done_data   = (bus.done_valid && is_read) ? pop_q : 8'h00;
   assign bus.done_is_ret = in_spwb && op_q == OP_RET;
   assign bus.err         = state_q == ERR;
endmodule
